placement_planner: RTL and testbench
====================================

// Module: placement_planner
// PURPOSE
//  Initiator side of the board next-state simulator handshake: for one falling tile, sweeps all
//  (rotation, column) candidates, issues one simulation request per candidate, scores each legal
//  result by a row-serial scan and reports the best placement. Sits between game control and the sim.
// PARAMETERS
//  NUM_COLS  10  candidate columns swept per rotation (0..NUM_COLS-1)
//  LINE_W     8  score weight per cleared line (0..15)
//  HEIGHT_W   1  score penalty per unit of stack height (0..15)
//  HOLE_W     2  score penalty per hole (0..15)
//  TIMEOUT   64  max cycles in WAIT before abort
// PORTS
//  clk              in   1    clock
//  rst              in   1    synchronous reset, active-high
//  start            in   1    begin search; sampled only in IDLE
//  board            in   200  current board, row r = [r*10+:10], row 0 top, row 19 bottom
//  block            in   4    tile type 1..7
//  busy             out  1    high from the cycle after start until DONE
//  done             out  1    1-cycle pulse, search finished
//  found            out  1    at least one legal candidate (valid with done)
//  error            out  1    sim timeout (valid with done)
//  best_rot         out  2    best rotation
//  best_col         out  4    best column
//  best_score       out  16   signed score of best candidate
//  best_board       out  200  resulting board of best candidate
//  sim_request      out  1    request to simulator
//  sim_block/sim_col/sim_rotation/sim_board  out  4/4/2/200  candidate under test
//  sim_valid        in   1    candidate legal
//  sim_next_board   in   200  resulting board
//  sim_cleared_lines in  10   lines cleared
//  sim_ready        in   1    1-cycle result strobe
// BEHAVIOUR
//  - Reset: all outputs 0, FSM to IDLE, best_score = 16'h8000; rst mid-search aborts, no done.
//  - Interface rules (decided): one clock, clk; synchronous active-high reset, rst.
//  - IDLE: on start latch board/block, rot=0, col=0, clear best registers; -> ISSUE.
//  - ISSUE (1 cycle): sim_request=1; sim_* driven from latched regs, held stable until sim_ready; -> WAIT.
//  - WAIT: sim_request=0; on sim_ready latch sim_valid/next_board/cleared_lines; valid -> SCAN,
//    else -> NEXT. Watchdog counts WAIT cycles; at TIMEOUT set error, -> DONE.
//  - SCAN (20 cycles, row 0..19): seen|=row; holes+=popcount(~row & seen_prev);
//    height = 20 - first nonempty row index (0 if empty).
//  - NEXT (1 cycle): score = LINE_W*lines - HEIGHT_W*height - HOLE_W*holes, 16-bit signed.
//    Replace best only if score > best_score (strict: ties keep earlier candidate); found|=valid.
//    Advance col; at NUM_COLS-1 wrap col to 0, rot+1; after rot 3/col NUM_COLS-1 -> DONE; else ISSUE.
//  - Order: rotation outer, column inner. Re-request never earlier than 1 cycle after sim_ready.
//  - Latency: legal candidate 23 cycles (ISSUE, WAIT, 20 SCAN, NEXT), illegal 3; full 4x10 legal = 920+1.
//  - DONE (1 cycle): done=1, busy=0; best_* and found/error held until next start; -> IDLE.
//  - start while busy ignored; sim_ready outside WAIT ignored.
// CONFIGURATION
//  SKIP_SYMMETRIC_EN defined: block 1 sweeps rotation 0 only; blocks 3,4 sweep rotations 0,1 only;
//  others all 4. Undefined: all blocks sweep rotations 0..3 (results identical, fewer cycles when defined).
// TESTING
//  1 Scripted responder, all sim_valid=0 -> done after 40*3+1 cycles, found=0, error=0, best_score=16'h8000.
//  2 Real board sim, empty board, block 1 -> best_rot=0, best_col=1, best_score=-2, found=1.
//  3 Scripted: only rot2/col5 returns lines=4 on empty result -> best_rot=2, best_col=5, best_score=32.
//  4 Scripted equal scores for every legal candidate -> first legal (lowest rot, then col) reported.
//  5 Responder never asserts sim_ready -> error=1, done after TIMEOUT cycles in WAIT, sim_request low.
//  6 rst at SCAN of candidate 7 -> all outputs 0 next cycle; new start completes normal sweep.

Source files
------------

// File: rtl/placement_planner.sv
// Sweeps every (rotation, column) candidate for one tile through the board simulator,
// scores legal results row-serially and keeps the best. SKIP_SYMMETRIC_EN trims redundant rotations.
module placement_planner #(
  parameter int NUM_COLS = 10,
  parameter int LINE_W   = 8,
  parameter int HEIGHT_W = 1,
  parameter int HOLE_W   = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [199:0] board_i,
  input  logic [3:0]   block_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         found_o,
  output logic         error_o,
  output logic [1:0]   best_rot_o,
  output logic [3:0]   best_col_o,
  output logic [15:0]  best_score_o,
  output logic [199:0] best_board_o,
  output logic         sim_request_o,
  output logic [3:0]   sim_block_o,
  output logic [3:0]   sim_col_o,
  output logic [1:0]   sim_rotation_o,
  output logic [199:0] sim_board_o,
  input  logic         sim_valid_i,
  input  logic [199:0] sim_next_board_i,
  input  logic [9:0]   sim_cleared_lines_i,
  input  logic         sim_ready_i
);
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SCAN, NEXT, DONE} state_t;

  state_t        state_q, state_d;
  logic [199:0]  board_q, board_d, nb_q, nb_d, best_board_q, best_board_d;
  logic [3:0]    block_q, block_d, col_q, col_d, best_col_q, best_col_d;
  logic [1:0]    rot_q, rot_d, best_rot_q, best_rot_d, last_rot;
  logic [9:0]    lines_q, lines_d, seen_q, seen_d, row_w;
  logic          valid_q, valid_d, found_q, found_d, error_q, error_d;
  logic [4:0]    row_q, row_d, height_q, height_d;
  logic [7:0]    holes_q, holes_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic signed [15:0] best_score_q, best_score_d, score_w;
  logic signed [31:0] score_full;

  function automatic logic [3:0] popcnt10(input logic [9:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 10; i++) n = n + {3'b0, v[i]};
    return n;
  endfunction

`ifdef SKIP_SYMMETRIC_EN
  // O-like tile has one distinct orientation, S/Z-like tiles have two.
  always_comb begin
    if (block_q == 4'd1)                          last_rot = 2'd0;
    else if (block_q == 4'd3 || block_q == 4'd4)  last_rot = 2'd1;
    else                                          last_rot = 2'd3;
  end
`else
  assign last_rot = 2'd3;
`endif

  assign row_w      = nb_q[int'(row_q)*10 +: 10];
  assign score_full = LINE_W * int'(lines_q) - HEIGHT_W * int'(height_q) - HOLE_W * int'(holes_q);
  assign score_w    = score_full[15:0];

  always_comb begin
    state_d      = state_q;
    board_d      = board_q;
    block_d      = block_q;
    rot_d        = rot_q;
    col_d        = col_q;
    nb_d         = nb_q;
    lines_d      = lines_q;
    valid_d      = valid_q;
    row_d        = row_q;
    seen_d       = seen_q;
    holes_d      = holes_q;
    height_d     = height_q;
    wdog_d       = wdog_q;
    found_d      = found_q;
    error_d      = error_q;
    best_rot_d   = best_rot_q;
    best_col_d   = best_col_q;
    best_score_d = best_score_q;
    best_board_d = best_board_q;
    case (state_q)
      IDLE: if (start_i) begin
        board_d      = board_i;
        block_d      = block_i;
        rot_d        = '0;
        col_d        = '0;
        found_d      = 1'b0;
        error_d      = 1'b0;
        best_rot_d   = '0;
        best_col_d   = '0;
        best_score_d = 16'sh8000;
        best_board_d = '0;
        state_d      = ISSUE;
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wdog_d = wdog_q + 1'b1;
        if (sim_ready_i) begin
          valid_d  = sim_valid_i;
          nb_d     = sim_next_board_i;
          lines_d  = sim_cleared_lines_i;
          row_d    = '0;
          seen_d   = '0;
          holes_d  = '0;
          height_d = '0;
          state_d  = sim_valid_i ? SCAN : NEXT;
        end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = DONE;
        end
      end
      SCAN: begin
        // A hole is an empty cell with something already seen above it in that column.
        seen_d  = seen_q | row_w;
        holes_d = holes_q + {4'b0, popcnt10(~row_w & seen_q)};
        if (seen_q == '0 && row_w != '0) height_d = 5'd20 - row_q;
        row_d = row_q + 1'b1;
        if (row_q == 5'd19) state_d = NEXT;
      end
      NEXT: begin
        if (valid_q) begin
          found_d = 1'b1;
          if (score_w > best_score_q) begin
            best_rot_d   = rot_q;
            best_col_d   = col_q;
            best_score_d = score_w;
            best_board_d = nb_q;
          end
        end
        state_d = ISSUE;
        if (col_q == 4'(NUM_COLS - 1)) begin
          col_d = '0;
          if (rot_q == last_rot) state_d = DONE;
          else                   rot_d   = rot_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      board_q      <= '0;
      block_q      <= '0;
      rot_q        <= '0;
      col_q        <= '0;
      nb_q         <= '0;
      lines_q      <= '0;
      valid_q      <= 1'b0;
      row_q        <= '0;
      seen_q       <= '0;
      holes_q      <= '0;
      height_q     <= '0;
      wdog_q       <= '0;
      found_q      <= 1'b0;
      error_q      <= 1'b0;
      best_rot_q   <= '0;
      best_col_q   <= '0;
      best_score_q <= 16'sh8000;
      best_board_q <= '0;
    end else begin
      state_q      <= state_d;
      board_q      <= board_d;
      block_q      <= block_d;
      rot_q        <= rot_d;
      col_q        <= col_d;
      nb_q         <= nb_d;
      lines_q      <= lines_d;
      valid_q      <= valid_d;
      row_q        <= row_d;
      seen_q       <= seen_d;
      holes_q      <= holes_d;
      height_q     <= height_d;
      wdog_q       <= wdog_d;
      found_q      <= found_d;
      error_q      <= error_d;
      best_rot_q   <= best_rot_d;
      best_col_q   <= best_col_d;
      best_score_q <= best_score_d;
      best_board_q <= best_board_d;
    end
  end

  assign busy_o         = (state_q == ISSUE) || (state_q == WAIT) || (state_q == SCAN) || (state_q == NEXT);
  assign done_o         = (state_q == DONE);
  assign found_o        = found_q;
  assign error_o        = error_q;
  assign best_rot_o     = best_rot_q;
  assign best_col_o     = best_col_q;
  assign best_score_o   = best_score_q;
  assign best_board_o   = best_board_q;
  assign sim_request_o  = (state_q == ISSUE);
  assign sim_block_o    = block_q;
  assign sim_col_o      = col_q;
  assign sim_rotation_o = rot_q;
  assign sim_board_o    = board_q;

endmodule

// File: tb/tb_placement_planner.sv
// Directed bench for placement_planner: scripted / modelled simulator responder on the negedge.
module tb_placement_planner;
  logic         clk = 1'b0;
  logic         rst, start_i;
  logic [199:0] board_i;
  logic [3:0]   block_i;
  logic         busy_o, done_o, found_o, error_o;
  logic [1:0]   best_rot_o;
  logic [3:0]   best_col_o;
  logic [15:0]  best_score_o;
  logic [199:0] best_board_o;
  logic         sim_request_o;
  logic [3:0]   sim_block_o, sim_col_o;
  logic [1:0]   sim_rotation_o;
  logic [199:0] sim_board_o;
  logic         sim_valid_i, sim_ready_i;
  logic [199:0] sim_next_board_i;
  logic [9:0]   sim_cleared_lines_i;

  int n_chk = 0, n_pass = 0;
  int mode = 1;
  logic pend = 1'b0;
  logic [199:0] hole_brd, exp_brd;

  always #5 clk = ~clk;

  placement_planner dut (
    .clk(clk), .rst(rst), .start_i(start_i), .board_i(board_i), .block_i(block_i),
    .busy_o(busy_o), .done_o(done_o), .found_o(found_o), .error_o(error_o),
    .best_rot_o(best_rot_o), .best_col_o(best_col_o), .best_score_o(best_score_o),
    .best_board_o(best_board_o), .sim_request_o(sim_request_o), .sim_block_o(sim_block_o),
    .sim_col_o(sim_col_o), .sim_rotation_o(sim_rotation_o), .sim_board_o(sim_board_o),
    .sim_valid_i(sim_valid_i), .sim_next_board_i(sim_next_board_i),
    .sim_cleared_lines_i(sim_cleared_lines_i), .sim_ready_i(sim_ready_i)
  );

  task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic o_fits(input logic [199:0] b, input int c, input int r);
    return !b[r*10+c-1] && !b[r*10+c] && !b[(r+1)*10+c-1] && !b[(r+1)*10+c];
  endfunction

  // 2x2 tile occupying columns col-1..col, dropped straight down; no row ever fills here.
  task automatic o_model(input logic [199:0] b, input logic [3:0] col, output logic v,
                         output logic [199:0] nb);
    int c, r;
    c = int'(col);
    nb = b;
    v = 1'b0;
    if (c >= 1 && c <= 9 && o_fits(b, c, 0)) begin
      r = 0;
      while (r < 18 && o_fits(b, c, r + 1)) r++;
      v = 1'b1;
      nb[r*10+c-1] = 1'b1; nb[r*10+c] = 1'b1;
      nb[(r+1)*10+c-1] = 1'b1; nb[(r+1)*10+c] = 1'b1;
    end
  endtask

  // Responder: answers in the cycle after the request (first WAIT cycle); mode 5 never answers.
  initial begin
    logic v;
    logic [199:0] nb;
    sim_ready_i = 0; sim_valid_i = 0; sim_next_board_i = '0; sim_cleared_lines_i = '0;
    forever begin
      @(negedge clk);
      sim_ready_i = 0;
      sim_valid_i = 0;
      if (rst) pend = 0;
      if (pend) begin
        pend = 0;
        sim_ready_i = 1;
        case (mode)
          2: begin
            o_model(sim_board_o, sim_col_o, v, nb);
            sim_valid_i = v; sim_next_board_i = nb; sim_cleared_lines_i = '0;
          end
          3: begin
            sim_valid_i = (sim_rotation_o == 2 && sim_col_o == 5);
            sim_next_board_i = '0; sim_cleared_lines_i = 10'd4;
          end
          4: begin
            sim_valid_i = !(sim_rotation_o == 0 && sim_col_o < 3);
            sim_next_board_i = hole_brd; sim_cleared_lines_i = 10'd1;
          end
          default: begin
            sim_valid_i = 0; sim_next_board_i = '0; sim_cleared_lines_i = '0;
          end
        endcase
      end else if (sim_request_o && mode == 4) begin
        sim_ready_i = 1;  // stray strobe during ISSUE must be ignored
      end
      if (sim_request_o && mode != 5 && !rst) pend = 1;
    end
  end

  task automatic run(input int m, input logic [199:0] brd, input logic [3:0] blk, input bit inject,
                     output int cyc, output int nreq);
    mode = m; board_i = brd; block_i = blk;
    start_i = 1;
    @(negedge clk);
    start_i = 0;
    cyc = 1; nreq = 0;
    forever begin
      if (sim_request_o) nreq++;
      if (done_o) break;
      if (cyc >= 3000) begin
        chk("done_timeout", 0, 1);
        break;
      end
      @(negedge clk);
      cyc++;
      start_i = (inject && cyc == 50);
    end
  endtask

  initial begin
    int cyc, nreq, exp_c2;
    rst = 1; start_i = 0; board_i = '0; block_i = '0;
    hole_brd = '0; hole_brd[180] = 1'b1;  // one cell on row 18, empty below: height 2, 1 hole
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_found", found_o, 0);
    chk("rst_req", sim_request_o, 0);
    chk("rst_score", best_score_o, 16'h8000);

    // 1: nothing legal
    run(1, '0, 4'd5, 0, cyc, nreq);
    chk("t1_cycles", cyc, 121);
    chk("t1_nreq", nreq, 40);
    chk("t1_found", found_o, 0);
    chk("t1_error", error_o, 0);
    chk("t1_score", best_score_o, 16'h8000);
    @(negedge clk);

    // 2: modelled sim, empty board, O tile; col 0 illegal, ties keep rot0/col1
`ifdef SKIP_SYMMETRIC_EN
    exp_c2 = 211;
`else
    exp_c2 = 841;
`endif
    run(2, '0, 4'd1, 1, cyc, nreq);
    exp_brd = '0; exp_brd[180] = 1; exp_brd[181] = 1; exp_brd[190] = 1; exp_brd[191] = 1;
    chk("t2_cycles", cyc, exp_c2);
    chk("t2_rot", best_rot_o, 0);
    chk("t2_col", best_col_o, 1);
    chk("t2_score", best_score_o, 16'hFFFE);
    chk("t2_found", found_o, 1);
    chk("t2_board", best_board_o, exp_brd);
    @(negedge clk);

    // 3: single legal candidate with 4 lines
    run(3, '0, 4'd6, 0, cyc, nreq);
    chk("t3_cycles", cyc, 141);
    chk("t3_rot", best_rot_o, 2);
    chk("t3_col", best_col_o, 5);
    chk("t3_score", best_score_o, 16'd32);
    chk("t3_found", found_o, 1);
    @(negedge clk);

    // 4: equal scores (8-2-2=4) everywhere legal; first legal is rot0/col3
    run(4, '0, 4'd2, 0, cyc, nreq);
    chk("t4_cycles", cyc, 861);
    chk("t4_rot", best_rot_o, 0);
    chk("t4_col", best_col_o, 3);
    chk("t4_score", best_score_o, 16'd4);
    chk("t4_board", best_board_o, hole_brd);
    @(negedge clk);
    chk("t4_done_pulse", done_o, 0);
    chk("t4_held_col", best_col_o, 3);

    // 5: simulator never answers
    run(5, '0, 4'd7, 0, cyc, nreq);
    chk("t5_cycles", cyc, 66);
    chk("t5_error", error_o, 1);
    chk("t5_found", found_o, 0);
    chk("t5_nreq", nreq, 1);
    chk("t5_req", sim_request_o, 0);
    @(negedge clk);

    // 6: reset during SCAN of the 7th candidate, then a clean search
    mode = 4; board_i = '1; block_i = 4'd2;
    start_i = 1;
    @(negedge clk);
    start_i = 0;
    nreq = 0; cyc = 0;
    while (nreq < 7 && cyc < 500) begin
      if (sim_request_o) nreq++;
      if (nreq < 7) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("t6_reach", nreq, 7);
    repeat (5) @(negedge clk);
    chk("t6_busy_pre", busy_o, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("t6_busy", busy_o, 0);
    chk("t6_done", done_o, 0);
    chk("t6_found", found_o, 0);
    chk("t6_req", sim_request_o, 0);
    chk("t6_simcol", sim_col_o, 0);
    chk("t6_simboard", sim_board_o, 0);
    chk("t6_score", best_score_o, 16'h8000);
    @(negedge clk);
    chk("t6_no_done", done_o, 0);
    run(3, '0, 4'd6, 0, cyc, nreq);
    chk("t6b_cycles", cyc, 141);
    chk("t6b_rot", best_rot_o, 2);
    chk("t6b_col", best_col_o, 5);
    chk("t6b_score", best_score_o, 16'd32);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
